// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM shadow: shadow geometry, screen banks,
// clear-sequencer states and the CPU address decode.
package vram_pkg;

  localparam int unsigned SHADOW_AW    = 15;
  localparam int unsigned SHADOW_DEPTH = 1 << SHADOW_AW;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CPU_AW       = 16;

  localparam logic [2:0] SCREEN_BANK0 = 3'd5;
  localparam logic [2:0] SCREEN_BANK1 = 3'd7;

  typedef enum logic {IDLE, CLEAR} clr_state_e;

  typedef logic [SHADOW_AW-1:0] shadow_idx_t;

  typedef struct packed {
    shadow_idx_t       idx;
    logic [DATA_W-1:0] data;
  } shadow_wr_t;

  typedef struct packed {
    logic        hit;
    shadow_idx_t idx;
  } decode_t;

  // Map a CPU address onto a shadow index; only bank 5 / bank 7 accesses hit.
  function automatic decode_t shadow_decode(input logic [CPU_AW-1:0] addr,
                                            input logic m128,
                                            input logic [2:0] page);
    decode_t d;
    d.hit = 1'b0;
    d.idx = {1'b0, addr[SHADOW_AW-2:0]};
    case (addr[CPU_AW-1:CPU_AW-2])
      2'b01: d.hit = 1'b1;
      2'b11: begin
        if (m128 && page == SCREEN_BANK0) begin
          d.hit = 1'b1;
        end else if (m128 && page == SCREEN_BANK1) begin
          d.hit = 1'b1;
          d.idx[SHADOW_AW-1] = 1'b1;
        end
      end
      default: d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vram_shadow_if.sv
// CPU snoop bus plus video read port seen by the VRAM shadow.
interface vram_shadow_if;
  import vram_pkg::*;

  logic [CPU_AW-1:0]    addr;
  logic [DATA_W-1:0]    din;
  logic                 nMREQ;
  logic                 nWR;
  logic                 nRFSH;
  logic                 m128;
  logic [2:0]           page_ram;
  logic [SHADOW_AW-1:0] vram_addr;
  logic [DATA_W-1:0]    vram_dout;

  modport master (
    output addr, din, nMREQ, nWR, nRFSH, m128, page_ram, vram_addr,
    input  vram_dout
  );

  modport slave (
    input  addr, din, nMREQ, nWR, nRFSH, m128, page_ram, vram_addr,
    output vram_dout
  );
endinterface

// File: rtl/vram_dpram.sv
// Simple dual-port 32K x 8 block RAM: port A write-only, port B registered
// read-first.
module vram_dpram
  import vram_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              we_a,
  input  shadow_idx_t       addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  shadow_idx_t       addr_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [SHADOW_DEPTH];

  always_ff @(posedge clk_sys) begin
    if (we_a) begin
      mem[addr_a] <= din_a;
    end
  end

  // Separate process keeps the read old-data when both ports hit one index.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dout_b <= '0;
    end else begin
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/vram_shadow.sv
// Mirrors CPU writes to screen banks 5/7 into a dual-port shadow and serves the
// video controller with fixed 1-cycle reads; includes a full-clear sequencer.
module vram_shadow
  import vram_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = 8'h00,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk_sys,
  input  logic          reset,
  vram_shadow_if.slave  bus,
  input  logic          clear_req,
  output logic          busy
);

  logic        wr_act_c;
  logic        old_wr;
  logic        pend;
  logic        start_clr;
  shadow_wr_t  cap;
  clr_state_e  state;
  shadow_idx_t cnt;
  decode_t     dec_c;

  logic              we_c;
  shadow_idx_t       wr_idx_c;
  logic [DATA_W-1:0] wr_data_c;

  assign wr_act_c = ~bus.nMREQ & ~bus.nWR & bus.nRFSH;
  assign dec_c    = shadow_decode(bus.addr, bus.m128, bus.page_ram);

  // A pending snoop commit owns the write port; the clear stalls that cycle.
  assign we_c      = pend | (state == CLEAR);
  assign wr_idx_c  = pend ? cap.idx  : cnt;
  assign wr_data_c = pend ? cap.data : CLEAR_VALUE;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_wr    <= 1'b0;
      pend      <= 1'b0;
      cap       <= '0;
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      start_clr <= CLEAR_ON_RESET;
    end else begin
      old_wr <= wr_act_c;
      if (pend) begin
        pend <= 1'b0;
      end
      // Rising edge of the write strobe is the single capture point.
      if (wr_act_c && !old_wr && dec_c.hit) begin
        pend     <= 1'b1;
        cap.idx  <= dec_c.idx;
        cap.data <= bus.din;
      end
      case (state)
        IDLE: begin
          if (start_clr || clear_req) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            start_clr <= 1'b0;
          end
        end
        CLEAR: begin
          if (!pend) begin
            cnt <= cnt + SHADOW_AW'(1);
            if (cnt == '1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  vram_dpram u_dpram (
    .clk_sys (clk_sys),
    .reset   (reset),
    .we_a    (we_c),
    .addr_a  (wr_idx_c),
    .din_a   (wr_data_c),
    .addr_b  (bus.vram_addr),
    .dout_b  (bus.vram_dout)
  );

endmodule

// File: tb/tb_vram_shadow.sv
// Directed self-checking bench for vram_shadow (CLEAR_VALUE=AA, clear on reset).
module tb_vram_shadow;
  import vram_pkg::*;

  logic clk_sys = 1'b0;
  logic reset;
  logic clear_req;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   n;

  vram_shadow_if bus ();

  always #5 clk_sys = ~clk_sys;

  vram_shadow #(.CLEAR_VALUE(8'hAA), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .clear_req (clear_req),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.nMREQ = 1'b1;
    bus.nWR   = 1'b1;
    bus.nRFSH = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                           input logic nmreq, input logic nrfsh);
    bus.addr  = a;
    bus.din   = d;
    bus.nMREQ = nmreq;
    bus.nWR   = 1'b0;
    bus.nRFSH = nrfsh;
    repeat (3) tick();
    bus_idle();
    repeat (2) tick();
  endtask

  task automatic read_check(input string tag, input logic [14:0] idx, input logic [7:0] exp);
    bus.vram_addr = idx;
    tick();
    check(tag, 32'(bus.vram_dout), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    clear_req = 1'b0;
    bus_idle();
    bus.addr = '0;
    bus.din = '0;
    bus.m128 = 1'b0;
    bus.page_ram = 3'd0;
    bus.vram_addr = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(bus.vram_dout), 32'd0);

    // Clear starts the cycle after reset; abort it at cnt=1000 with reset.
    reset = 1'b0;
    tick();
    check("clr_start_busy", 32'(busy), 32'd1);
    repeat (1000) tick();
    check("midclr_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dout", 32'(bus.vram_dout), 32'd0);
    reset = 1'b0;
    tick();
    n = 0;
    while (busy && n < 40000) begin
      n++;
      tick();
    end
    check("clr_len", 32'(n), 32'd32768);
    read_check("clr_0000", 15'h0000, 8'hAA);
    read_check("clr_3fff", 15'h3FFF, 8'hAA);
    read_check("clr_4000", 15'h4000, 8'hAA);
    read_check("clr_7fff", 15'h7FFF, 8'hAA);

    // Snoop latency: new byte visible 3 cycles after the write edge.
    bus.vram_addr = 15'h0000;
    tick();
    bus.addr = 16'h4000;
    bus.din = 8'h5C;
    bus.nMREQ = 1'b0;
    bus.nWR = 1'b0;
    tick();
    check("lat_p0", 32'(bus.vram_dout), 32'hAA);
    tick();
    check("lat_p1", 32'(bus.vram_dout), 32'hAA);
    tick();
    check("lat_p2", 32'(bus.vram_dout), 32'h5C);
    bus_idle();
    tick();
    read_check("bank7_untouched", 15'h4000, 8'hAA);

    // Paged C000 window decode.
    bus.m128 = 1'b1;
    bus.page_ram = 3'd7;
    cpu_write(16'hC123, 8'h81, 1'b0, 1'b1);
    read_check("pg7_4123", 15'h4123, 8'h81);
    read_check("pg7_0123", 15'h0123, 8'hAA);
    bus.page_ram = 3'd5;
    cpu_write(16'hC123, 8'h82, 1'b0, 1'b1);
    read_check("pg5_0123", 15'h0123, 8'h82);
    read_check("pg5_4123", 15'h4123, 8'h81);
    bus.page_ram = 3'd3;
    cpu_write(16'hC123, 8'h99, 1'b0, 1'b1);
    read_check("pg3_0123", 15'h0123, 8'h82);
    read_check("pg3_4123", 15'h4123, 8'h81);
    bus.m128 = 1'b0;
    bus.page_ram = 3'd7;
    cpu_write(16'hC123, 8'h12, 1'b0, 1'b1);
    read_check("m48_4123", 15'h4123, 8'h81);
    read_check("m48_0123", 15'h0123, 8'h82);

    // Non-qualifying cycles and addresses.
    cpu_write(16'h4000, 8'h77, 1'b0, 1'b0);
    read_check("rfsh_0000", 15'h0000, 8'h5C);
    cpu_write(16'h4000, 8'h77, 1'b1, 1'b1);
    read_check("nomreq_0000", 15'h0000, 8'h5C);
    bus.m128 = 1'b1;
    bus.page_ram = 3'd5;
    cpu_write(16'h8000, 8'h44, 1'b0, 1'b1);
    read_check("a8000_0000", 15'h0000, 8'h5C);
    cpu_write(16'h0000, 8'h45, 1'b0, 1'b1);
    read_check("rom_0000", 15'h0000, 8'h5C);
    cpu_write(16'h7FFF, 8'h3C, 1'b0, 1'b1);
    read_check("a7fff_3fff", 15'h3FFF, 8'h3C);
    bus.m128 = 1'b0;

    // Same-cycle read/write is read-first.
    cpu_write(16'h4010, 8'h00, 1'b0, 1'b1);
    read_check("rf_old", 15'h0010, 8'h00);
    bus.addr = 16'h4010;
    bus.din = 8'hFF;
    bus.nMREQ = 1'b0;
    bus.nWR = 1'b0;
    tick();
    tick();
    check("rf_same_cycle", 32'(bus.vram_dout), 32'h00);
    tick();
    check("rf_next_cycle", 32'(bus.vram_dout), 32'hFF);
    bus_idle();
    tick();

    // Requested clear with a snoop write injected and a repeated request.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("req_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40000) begin
      n++;
      if (n == 10) begin
        bus.addr = 16'h7FFF;
        bus.din = 8'h33;
        bus.nMREQ = 1'b0;
        bus.nWR = 1'b0;
      end
      if (n == 14) bus_idle();
      if (n == 20) clear_req = 1'b1;
      if (n == 21) clear_req = 1'b0;
      if (n == 25) bus.vram_addr = 15'h3FFF;
      if (n == 27) check("live_read", 32'(bus.vram_dout), 32'h33);
      tick();
    end
    check("req_len", 32'(n), 32'd32769);
    read_check("req_3fff", 15'h3FFF, 8'hAA);
    read_check("req_0000", 15'h0000, 8'hAA);
    read_check("req_0010", 15'h0010, 8'hAA);
    read_check("req_4123", 15'h4123, 8'hAA);
    check("idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_shadow.md
Name: vram_shadow

Overview:
- Upstream of the video controller: keeps a 32 KB shadow of RAM banks 5 and 7 in dual-port block RAM.
- Snoops CPU memory writes and mirrors those aimed at screen banks into the shadow.
- Serves the video controller's 15-bit vram_addr with fixed 1-cycle read latency, independent of CPU/SDRAM timing.
- Includes a clear sequencer so the screen starts at a defined value after reset or on request.

Parameters:
- CLEAR_VALUE, 8'h00, byte written to every shadow location by the clear sequencer.
- CLEAR_ON_RESET, 1, 1 = start a full clear when reset deasserts; 0 = shadow contents untouched by reset.

Ports:
- clk_sys  in  1  master clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- addr  in  16  CPU address bus.
- din  in  8  CPU data out (write data).
- nMREQ  in  1  CPU memory request, active low.
- nWR  in  1  CPU write strobe, active low.
- nRFSH  in  1  CPU refresh, active low.
- m128  in  1  128K paging enabled.
- page_ram  in  3  bank mapped at C000-FFFF.
- clear_req  in  1  pulse: start full clear.
- vram_addr  in  15  video read address; bit14 = bank (0 = bank5, 1 = bank7), bits13:0 = offset.
- vram_dout  out  8  read data, valid 1 cycle after vram_addr.
- busy  out  1  clear sequencer active.

Behaviour:
- Reset values: vram_dout 0, busy 0, write-pending flag 0, clear FSM IDLE, clear counter 0. Shadow RAM contents are not reset.
- Write detect: wr_act = ~nMREQ & ~nWR & nRFSH, registered as old_wr each cycle. Rising edge of wr_act (~old_wr & wr_act) is the single capture point per access. At capture, register addr and din.
- Decode at capture; shadow index is 15 bits:
  - 4000-7FFF: index {0, addr[13:0]}.
  - C000-FFFF with m128=1 and page_ram=5: index {0, addr[13:0]}.
  - C000-FFFF with m128=1 and page_ram=7: index {1, addr[13:0]}.
  - Anything else, including C000-FFFF with m128=0: ignored.
- A qualifying capture sets pend=1. The write port commits the pend entry on the next cycle, then clears pend. Snoop write latency is 2 cycles from the edge to the RAM update.
- A new capture arriving while pend=1 cannot occur: Z80 writes are at least 3 T-states apart, which is many clk_sys cycles. No queue is required. If it does occur, the newer capture overwrites pend.
- Read port: registered read, vram_dout <= ram[vram_addr] every cycle; latency exactly 1.
- Read and write to the same index in the same cycle is read-first: vram_dout returns the old byte and the new byte is visible the following cycle.
- Clear FSM states:
  - IDLE -> CLEAR on the cycle after reset deasserts (if CLEAR_ON_RESET=1), or on clear_req=1 while in IDLE.
  - CLEAR: each cycle writes CLEAR_VALUE to ram[cnt] and increments cnt, except on cycles where pend=1. A snoop commit owns the write port that cycle and cnt holds.
  - After writing index 32767, cnt wraps to 0 and the FSM returns to IDLE.
  - busy = (state==CLEAR).
  - clear_req while in CLEAR is ignored; it does not restart the clear.
  - Reset mid-clear: FSM goes to IDLE, cnt to 0, then restarts per CLEAR_ON_RESET.
- A CPU write landing at an index the clear has not yet reached is later overwritten by CLEAR_VALUE. This is accepted behaviour: software does not write VRAM during boot clear.
- Read port is always live, including during CLEAR.

Decomposition:
- Shared package vram_pkg:
  - SHADOW_AW = 15.
  - SCREEN_BANK0 = 3'd5, SCREEN_BANK1 = 3'd7.
  - clear FSM state enum {IDLE, CLEAR}.
- One sub-module, vram_dpram:
  - simple dual-port 32K x 8.
  - port A write-only, port B registered read-first.
  - inferable block RAM.
- Decode, pend register and FSM stay in vram_shadow.

Test Plan:
- CLEAR_ON_RESET=1, CLEAR_VALUE=8'hAA, release reset: busy high for exactly 32768 cycles. Then reads at 0000, 3FFF, 4000 and 7FFF return AA.
- After clear, CPU write 0x4000 <= 0x5C (m128=0): vram_dout at vram_addr 0x0000 reads 5C starting 3 cycles after the nWR edge. Reads at 0x4000 are unchanged.
- m128=1, page_ram=7, write 0xC123 <= 0x81: index 0x4123 reads 81. Repeat with page_ram=5: index 0x0123 updated. Repeat with page_ram=3: no change anywhere.
- m128=0, write 0xC123 <= 0x12: no shadow change. Write with nRFSH=0 (refresh cycle) or nMREQ=1: no change.
- During CLEAR, inject a write at 0x7FFF <= 0x33: busy extends by 1 cycle. After clear completes, index 0x3FFF reads CLEAR_VALUE because the clear had not yet passed it.
- Same-cycle read/write of index 0x0010 (old 00, new FF): first read returns 00, next cycle returns FF. Assert reset mid-clear at cnt=1000: busy drops, then a full 32768-cycle clear restarts.
